// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RV32I/RV64I immediate generator with a one-stage
// valid/ready output register, format code, illegal-opcode flag and a
// saturating illegal-opcode counter for debug readout.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instrucao,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  immediate,
  output logic [2:0]       formato,
  output logic             ilegal,
  output logic [CNT_W-1:0] ilegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_SHAMT   = 3'd6,
    FMT_ILLEGAL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [5:0]      shamt;
  logic [XLEN-1:0] imm_d;
  fmt_e            fmt_d;
  fmt_e            fmt_q;
  logic            accept;

  assign opcode   = instrucao[6:0];
  assign funct3   = instrucao[14:12];
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign formato  = fmt_q;

  // Decode format and build the 32-bit immediate; widen to XLEN afterwards
  // (sign-extend for all formats except the zero-extended shift amount).
  always_comb begin
    fmt_d = FMT_ILLEGAL;
    imm32 = '0;
    imm_d = '0;
    shamt = (XLEN == 64) ? instrucao[25:20] : {1'b0, instrucao[24:20]};
    case (opcode)
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt_d = FMT_I;
        imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
      end
      OP_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          fmt_d = FMT_SHAMT;
        end else begin
          fmt_d = FMT_I;
          imm32 = {{20{instrucao[31]}}, instrucao[31:20]};
        end
      end
      OP_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{instrucao[31]}}, instrucao[31:25], instrucao[11:7]};
      end
      OP_BRANCH: begin
        fmt_d = FMT_B;
        imm32 = {{19{instrucao[31]}}, instrucao[31], instrucao[7],
                 instrucao[30:25], instrucao[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {instrucao[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{11{instrucao[31]}}, instrucao[31], instrucao[19:12],
                 instrucao[20], instrucao[30:21], 1'b0};
      end
      OP_OP: fmt_d = FMT_R;
      default: fmt_d = FMT_ILLEGAL;
    endcase
    if (fmt_d == FMT_SHAMT) imm_d = XLEN'(shamt);
    else                    imm_d = XLEN'($signed(imm32));
  end

  // Output register and saturating illegal counter; only accepted words update data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      immediate  <= '0;
      fmt_q      <= FMT_R;
      ilegal     <= 1'b0;
      ilegal_cnt <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      immediate <= imm_d;
      fmt_q     <= fmt_d;
      ilegal    <= (fmt_d == FMT_ILLEGAL);
      if (fmt_d == FMT_ILLEGAL && ilegal_cnt != '1)
        ilegal_cnt <= ilegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: scoreboard bench driving two instances in lockstep,
// a default RV32 one and an RV64 one with a 2-bit illegal counter.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_ilegal;
  logic [31:0] a_immediate;
  logic [2:0]  a_formato;
  logic [7:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_ilegal;
  logic [63:0] b_immediate;
  logic [2:0]  b_formato;
  logic [1:0]  b_cnt;

  exp_t qa[$];
  exp_t qb[$];
  int   total = 0;
  int   bad   = 0;
  logic [7:0] cnta = 0;
  logic [7:0] cntb = 0;

  imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .instrucao(instr), .out_valid(a_out_valid), .out_ready(out_ready),
    .immediate(a_immediate), .formato(a_formato), .ilegal(a_ilegal),
    .ilegal_cnt(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .instrucao(instr), .out_valid(b_out_valid), .out_ready(out_ready),
    .immediate(b_immediate), .formato(b_formato), .ilegal(b_ilegal),
    .ilegal_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word and hold it until accepted; expectations are queued on accept.
  task automatic send(input logic [31:0] w, input logic [31:0] ea, input logic [63:0] eb,
                      input logic [2:0] f, input logic il, output int waits);
    exp_t e;
    in_valid = 1'b1;
    instr    = w;
    waits    = 0;
    @(negedge clk);
    while (!a_in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!a_in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: word 0x%08h never accepted", w);
    end else begin
      chk("in_ready_match", {63'd0, b_in_ready}, {63'd0, a_in_ready});
      if (il) begin
        cnta = cnta + 8'd1;
        if (cntb != 8'd3) cntb = cntb + 8'd1;
      end
      e.imm = {32'd0, ea}; e.fmt = f; e.ill = il; e.cnt = cnta;
      qa.push_back(e);
      e.imm = eb; e.cnt = cntb;
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = $urandom;
  endtask

  // Monitors: compare whenever a transfer is about to happen on the output side.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n === 1'b1 && a_out_valid === 1'b1 && out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_output: got 0x%08h expected none", a_immediate);
      end else begin
        e = qa.pop_front();
        chk("a_immediate", {32'd0, a_immediate}, e.imm);
        chk("a_formato", {61'd0, a_formato}, {61'd0, e.fmt});
        chk("a_ilegal", {63'd0, a_ilegal}, {63'd0, e.ill});
        chk("a_ilegal_cnt", {56'd0, a_cnt}, {56'd0, e.cnt});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n === 1'b1 && b_out_valid === 1'b1 && out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_output: got 0x%016h expected none", b_immediate);
      end else begin
        e = qb.pop_front();
        chk("b_immediate", b_immediate, e.imm);
        chk("b_formato", {61'd0, b_formato}, {61'd0, e.fmt});
        chk("b_ilegal", {63'd0, b_ilegal}, {63'd0, e.ill});
        chk("b_ilegal_cnt", {62'd0, b_cnt}, {56'd0, e.cnt});
      end
    end
  end

  initial begin : stim
    int w;
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'hFFF00093;
    out_ready = 1'b1;

    // Reset held two edges with a valid word presented
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_a_cnt", {56'd0, a_cnt}, 64'd0);
    chk("rst_a_imm", {32'd0, a_immediate}, 64'd0);
    chk("rst_a_fmt", {61'd0, a_formato}, 64'd0);
    chk("rst_a_ilegal", {63'd0, a_ilegal}, 64'd0);
    chk("rst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    chk("rst_b_cnt", {62'd0, b_cnt}, 64'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    send(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, w);

    // Back-to-back stream: each word must be taken without waiting
    send(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0, w); chk("thru_sw", 64'(w), 64'd0);
    send(32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0, w); chk("thru_beq", 64'(w), 64'd0);
    send(32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd4, 1'b0, w); chk("thru_lui", 64'(w), 64'd0);
    send(32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0, w); chk("thru_jal", 64'(w), 64'd0);
    send(32'h01F09093, 32'h0000001F, 64'h000000000000001F, 3'd6, 1'b0, w); chk("thru_slli", 64'(w), 64'd0);
    send(32'h00412083, 32'h00000004, 64'h0000000000000004, 3'd1, 1'b0, w);
    send(32'h002080B3, 32'h00000000, 64'h0000000000000000, 3'd0, 1'b0, w);
    send(32'hFFFFF097, 32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0, w);

    // Drain without new input: valid drops, data holds
    @(posedge clk);
    #1;
    chk("drain_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("drain_imm_hold", {32'd0, a_immediate}, 64'h00000000FFFFF000);

    // Backpressure: held output, new word presented, in_ready low
    send(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0, w);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h00412083;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {63'd0, a_in_ready}, 64'd0);
      chk("stall_out_valid", {63'd0, a_out_valid}, 64'd1);
      chk("stall_imm", {32'd0, a_immediate}, 64'h00000000FFFFFFFF);
      chk("stall_fmt", {61'd0, a_formato}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h00412083, 32'h00000004, 64'h0000000000000004, 3'd1, 1'b0, w);
    chk("stall_release_same_cycle", 64'(w), 64'd0);

    // Illegal opcodes: A counts to 5, B saturates at 3
    send(32'h00000000, 32'h0, 64'h0, 3'd7, 1'b1, w);
    send(32'h0000007F, 32'h0, 64'h0, 3'd7, 1'b1, w);
    send(32'h0000000B, 32'h0, 64'h0, 3'd7, 1'b1, w);
    send(32'hFFFFFFFF, 32'h0, 64'h0, 3'd7, 1'b1, w);
    send(32'h00000000, 32'h0, 64'h0, 3'd7, 1'b1, w);
    @(posedge clk);
    #1;
    chk("cnt_a_five", {56'd0, a_cnt}, 64'd5);
    chk("cnt_b_saturated", {62'd0, b_cnt}, 64'd3);

    // Width-dependent extension
    send(32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, 1'b0, w);
    send(32'h03F09093, 32'h0000001F, 64'h000000000000003F, 3'd6, 1'b0, w);

    // Reset in the middle of a stall discards the held output
    send(32'h00000000, 32'h0, 64'h0, 3'd7, 1'b1, w);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", {63'd0, a_out_valid}, 64'd1);
    qa.delete();
    qb.delete();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_a_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("midrst_a_cnt", {56'd0, a_cnt}, 64'd0);
    chk("midrst_b_out_valid", {63'd0, b_out_valid}, 64'd0);
    chk("midrst_b_cnt", {62'd0, b_cnt}, 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cnta      = 8'd0;
    cntb      = 8'd0;
    send(32'h0000007F, 32'h0, 64'h0, 3'd7, 1'b1, w);

    // Let the monitors consume what is left, bounded
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("qa_empty", 64'(qa.size()), 64'd0);
    chk("qb_empty", 64'(qb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Registered, parametrised immediate generator for the RV32I/RV64I datapath. It covers all base formats (I, S, B, U, J, shift-immediate, R) where the current combinational generator covers only LW, I-type, SW and BEQ. It sits between fetch/decode and the ALU operand mux, with a one-stage valid/ready pipeline register. It reports a format code and an illegal-opcode flag, and keeps a saturating count of illegal opcodes for the simulator's debug readout.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; immediates sign-extended to XLEN.
CNT_W, 8, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  input  1  instrucao is valid this cycle.
in_ready  output  1  block can accept an instruction this cycle.
instrucao  input  32  raw instruction word.
out_valid  output  1  immediate, formato and ilegal are valid.
out_ready  input  1  consumer accepts the output this cycle.
immediate  output  XLEN  decoded, sign/zero-extended immediate.
formato  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SHAMT=6, ILLEGAL=7.
ilegal  output  1  opcode not recognised.
ilegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (rst_n=0 at posedge): out_valid=0, immediate=0, formato=0, ilegal=0, ilegal_cnt=0. Reset overrides any simultaneous transfer, and any held output is discarded.
- in_ready = !out_valid || out_ready. It is combinational, with no dependency on in_valid.
- Accept when in_valid && in_ready. Outputs are registered on that edge, so latency is 1 cycle.
- If out_valid && !out_ready, all outputs hold stable.
- Simultaneous drain and accept in one cycle gives full throughput: one instruction per cycle.
- If out_ready && !accept, out_valid goes to 0 and the data registers keep their old values.
- Decode on opcode = instrucao[6:0], funct3 = instrucao[14:12]:
  - 0000011 LOAD, 0010011 OP-IMM (except shifts), 1100111 JALR, 1110011 SYSTEM: I. imm = sext(inst[31:20]).
  - OP-IMM with funct3 001 or 101: SHAMT. imm = zext(inst[24:20]) if XLEN=32, zext(inst[25:20]) if XLEN=64. The funct7 bits are not checked.
  - 0100011 STORE: S. imm = sext({inst[31:25], inst[11:7]}).
  - 1100011 BRANCH: B. imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - 0110111 LUI, 0010111 AUIPC: U. imm = sext({inst[31:12], 12'b0}).
  - 1101111 JAL: J. imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - 0110011 OP: R. imm = 0.
  - Any other opcode: ILLEGAL. imm = 0, ilegal=1.
- Sign extension always replicates inst[31] up to XLEN-1.
- ilegal_cnt increments by 1 on each accepted illegal instruction and saturates at 2^CNT_W-1, never wrapping. Stalled cycles do not count.
- Only accepted instructions update any register. instrucao is ignored while !in_valid.

Test Plan:
- Reset with rst_n=0 for 2 cycles while in_valid=1 -> out_valid=0, ilegal_cnt=0. Release, then addi 0xFFF00093 -> next cycle immediate=0xFFFFFFFF, formato=1.
- Back-to-back stream with out_ready=1: sw 0xFE112E23, beq 0xFE000CE3, lui 0x123450B7, jal 0xFFDFF0EF, slli 0x01F09093 -> consecutive cycles give 0xFFFFFFFC/2, 0xFFFFFFF8/3, 0x12345000/4, 0xFFFFFFFC/5, 0x0000001F/6.
- Backpressure: accept 0xFFF00093, then hold out_ready=0 for 3 cycles with a new instruction presented -> in_ready=0, outputs stay 0xFFFFFFFF/1. Raise out_ready -> the new word is accepted that same cycle.
- Illegal: accept 0x00000000 -> formato=7, ilegal=1, immediate=0, ilegal_cnt=1. With CNT_W=2, 5 illegal instructions -> ilegal_cnt=3.
- XLEN=64: lui 0x800000B7 -> immediate=0xFFFFFFFF80000000. slli 0x03F09093 -> immediate=0x3F.
- Reset mid-stall: out_valid=1, out_ready=0, pulse rst_n=0 for one edge -> out_valid=0, ilegal_cnt=0 on that edge.
